// File: rtl/sadd_pkg.sv
// sadd_pkg: shared types and constants for the serial-adder scheduler.
//   sadd_state_e : scheduler FSM states
//   OP_W_DEF     : default operand width (serialised MSB-first)
//   RES_W_DEF    : default result width (one carry bit wider than the operands)
//   id_w(n)      : width of a requester index for n requesters
package sadd_pkg;

   typedef enum logic [2:0] {
      S_DRAIN = 3'd0,
      S_IDLE  = 3'd1,
      S_SEND  = 3'd2,
      S_WAIT  = 3'd3,
      S_RECV  = 3'd4,
      S_RESP  = 3'd5
   } sadd_state_e;

   localparam int OP_W_DEF  = 2;
   localparam int RES_W_DEF = OP_W_DEF + 1;

   // A single requester still needs a 1-bit index field.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sadd_sched_rr_arb.sv
// rr_arb: combinational arbiter for the serial-adder scheduler.
//   Default build: round-robin, the search starts at index ptr and wraps.
//   With SADD_FIXED_PRIO_EN defined: ptr is ignored (tied to 0), so the
//   lowest requesting index always wins.
// Ports:
//   req  in  N     request vector
//   ptr  in  IW    index the search starts from
//   gnt  out N     one-hot grant (all zero when no request)
//   idx  out IW    encoded index of the granted requester
module rr_arb
   import sadd_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] ptr_eff;
   logic [IW:0]   cand_w;
   logic [IW-1:0] cand;
   logic          found;

`ifdef SADD_FIXED_PRIO_EN
   assign ptr_eff = '0;
`else
   assign ptr_eff = ptr;
`endif

   // NOTE: every signal written here gets a default before the loop, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      found  = 1'b0;
      cand_w = '0;
      cand   = '0;
      for (int i = 0; i < N; i++) begin
         // One extra bit lets ptr+i exceed N-1 before folding back, so the
         // wrap is correct for non-power-of-two N too.
         cand_w = {1'b0, ptr_eff} + (IW + 1)'(i);
         if (cand_w >= (IW + 1)'(N)) begin
            cand_w = cand_w - (IW + 1)'(N);
         end
         cand = cand_w[IW-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/sadd_sched.sv
// sadd_sched: shares one serial adder between NUM_REQ parallel requesters.
// Per transaction it grants one requester, latches its operands, shifts them
// into the adder MSB-first behind a one-cycle start strobe, collects the
// serial result once the adder raises its result strobe, and returns the sum
// tagged with the requester index. A drain period of GAP idle cycles follows
// reset and every transaction, since the adder has no reset of its own.
// Optional build macro: SADD_FIXED_PRIO_EN (fixed priority, lowest index wins;
// the round-robin pointer is removed).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   NUM_REQ       pending request per requester
//   req_a      in   NUM_REQ*OP_W  operand A, requester i at [i*OP_W +: OP_W]
//   req_b      in   NUM_REQ*OP_W  operand B, same packing
//   req_ready  out  NUM_REQ       one-hot accept pulse
//   rsp_valid  out  one-cycle response strobe
//   rsp_id     out  requester index of the response
//   rsp_data   out  RES_W-bit sum (0 on error)
//   rsp_err    out  adder timed out
//   busy       out  FSM not in IDLE
//   add_en     out  adder start strobe
//   add_a      out  serial operand A bit
//   add_b      out  serial operand B bit
//   add_en_i   in   adder result strobe
//   add_out    in   adder serial result bit
module sadd_sched
   import sadd_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int OP_W    = OP_W_DEF,
   parameter int RES_W   = RES_W_DEF,
   parameter int TIMEOUT = 16,
   parameter int GAP     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*OP_W-1:0]      req_a,
   input  logic [NUM_REQ*OP_W-1:0]      req_b,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rsp_valid,
   output logic [id_w(NUM_REQ)-1:0]     rsp_id,
   output logic [RES_W-1:0]             rsp_data,
   output logic                         rsp_err,
   output logic                         busy,
   output logic                         add_en,
   output logic                         add_a,
   output logic                         add_b,
   input  logic                         add_en_i,
   input  logic                         add_out
);

   localparam int ID_W  = id_w(NUM_REQ);
   localparam int MAX1  = (TIMEOUT > GAP) ? TIMEOUT : GAP;
   localparam int MAX2  = (MAX1 > RES_W) ? MAX1 : RES_W;
   localparam int CNT_W = $clog2(MAX2 + 1);

   sadd_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;      // gap, bit or timeout count depending on state
   logic [OP_W-1:0]   op_a_q, op_b_q;
   logic [RES_W-1:0]  res_q;
   logic              err_q;
   logic [ID_W-1:0]   id_q;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic [ID_W-1:0]    arb_ptr;
   logic [OP_W-1:0]    sel_a, sel_b;
   logic               any_req;
   logic               accept;

   assign any_req = |req_valid;
   assign accept  = (state_q == S_IDLE) && any_req;
   assign busy    = (state_q != S_IDLE);

   rr_arb #(.N(NUM_REQ), .IW(ID_W)) u_arb (
      .req (req_valid),
      .ptr (arb_ptr),
      .gnt (gnt),
      .idx (gnt_idx)
   );

`ifdef SADD_FIXED_PRIO_EN
   assign arb_ptr = '0;
`else
   logic [ID_W-1:0] rr_ptr_q;
   assign arb_ptr = rr_ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (accept) begin
         rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
   end
`endif

   // Operand mux driven by the one-hot grant; constant slices only.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_a = req_a[i*OP_W +: OP_W];
            sel_b = req_b[i*OP_W +: OP_W];
         end
      end
   end

   // Next state and all outputs; everything is idle unless a state says so.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      add_en    = 1'b0;
      add_a     = 1'b0;
      add_b     = 1'b0;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      unique case (state_q)
         S_DRAIN: begin
            if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (any_req) begin
               req_ready = gnt;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            // Operands shift left each cycle, so the MSB is always on top.
            add_a  = op_a_q[OP_W-1];
            add_b  = op_b_q[OP_W-1];
            add_en = (cnt_q == CNT_W'(OP_W - 1));
            if (cnt_q == '0) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (add_en_i) begin
               state_d = S_RECV;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_RESP;
            end
         end
         S_RECV: begin
            if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_id    = id_q;
            rsp_data  = res_q;
            rsp_err   = err_q;
            state_d   = S_DRAIN;
         end
         default: state_d = S_DRAIN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_DRAIN;
         cnt_q   <= CNT_W'(GAP);
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_DRAIN: begin
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
            S_IDLE: begin
               if (any_req) begin
                  op_a_q <= sel_a;
                  op_b_q <= sel_b;
                  id_q   <= gnt_idx;
                  err_q  <= 1'b0;
                  cnt_q  <= CNT_W'(OP_W - 1);
               end
            end
            S_SEND: begin
               op_a_q <= op_a_q << 1;
               op_b_q <= op_b_q << 1;
               // Reaching 0 doubles as clearing the timeout count for WAIT.
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
            S_WAIT: begin
               if (add_en_i) begin
                  res_q <= {{(RES_W - 1){1'b0}}, add_out};
                  cnt_q <= CNT_W'(RES_W - 1);
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  res_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RECV: begin
               res_q <= {res_q[RES_W-2:0], add_out};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            S_RESP: begin
               cnt_q <= CNT_W'(GAP);
            end
            default: cnt_q <= CNT_W'(GAP);
         endcase
      end
   end

endmodule

// File: tb/tb_sadd_sched.sv
// tb_sadd_sched: directed self-checking bench for sadd_sched with the default
// parameters (NUM_REQ=4, OP_W=2, RES_W=3, TIMEOUT=16, GAP=3).
// A behavioural serial adder answers each start strobe; its reply delay and
// a "never answer" mode are set by the stimulus.
module tb_sadd_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] req_a, req_b;
   logic [3:0] req_ready;
   logic       rsp_valid;
   logic [1:0] rsp_id;
   logic [2:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic       add_en, add_a, add_b;
   logic       add_en_i, add_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_grant  = 0;
   int m_dly    = 0;
   bit m_dead   = 1'b0;

   sadd_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .add_en    (add_en),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_en_i  (add_en_i),
      .add_out   (add_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serial adder model: captures two MSB-first bits after a start strobe,
   // then after m_dly extra cycles returns the 3-bit sum MSB-first.
   initial begin
      logic [1:0] ma, mb;
      logic [2:0] ms;
      add_en_i = 1'b0;
      add_out  = 1'b0;
      forever begin
         @(negedge clk);
         if (add_en === 1'b1) begin
            ma[1] = add_a;
            mb[1] = add_b;
            @(negedge clk);
            ma[0] = add_a;
            mb[0] = add_b;
            ms = {1'b0, ma} + {1'b0, mb};
            if (!m_dead) begin
               @(negedge clk);
               repeat (m_dly) @(negedge clk);
               add_en_i = 1'b1;
               add_out  = ms[2];
               @(negedge clk);
               add_en_i = 1'b0;
               add_out  = ms[1];
               @(negedge clk);
               add_out  = ms[0];
               @(negedge clk);
               add_out  = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required end before 200000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [1:0] a, input logic [1:0] b);
      req_a[idx*2 +: 2] = a;
      req_b[idx*2 +: 2] = b;
      req_valid[idx]    = 1'b1;
   endtask

   // Hold reset two cycles, check idle outputs, then measure the drain.
   task automatic do_reset(input string tag);
      int n;
      bit seen;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, "_outs"},
            {rsp_valid, rsp_err, rsp_data, rsp_id, add_en, add_a, add_b, req_ready}, 32'd0);
      check({tag, "_busy"}, busy, 32'd1);
      rst  = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (busy && n < 50) begin
         if (rsp_valid) seen = 1'b1;
         n++;
         @(negedge clk);
      end
      check({tag, "_drain_cycles"}, n, 32'd3);
      check({tag, "_no_rsp"}, seen, 32'd0);
   endtask

   // Wait for the accept pulse, check it, drop the request after the edge.
   task automatic grab(input string tag, input int idx, output int waits);
      int n;
      #1;
      n = 0;
      while (req_ready == '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, req_ready, 32'(1) << idx);
      waits   = n;
      t_grant = cyc;
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic serve(input string tag, input int idx, input logic [1:0] a,
                        input logic [1:0] b, input logic [2:0] exp_data,
                        input logic exp_err, input bit chk_ser,
                        output int waits, output int lat);
      int n;
      grab(tag, idx, waits);
      if (chk_ser) begin
         @(negedge clk);
         check({tag, "_bit1"}, {add_en, add_a, add_b}, {29'd0, 1'b1, a[1], b[1]});
         @(negedge clk);
         check({tag, "_bit0"}, {add_en, add_a, add_b}, {29'd0, 1'b0, a[0], b[0]});
      end
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      lat = cyc - t_grant;
      check({tag, "_rsp_valid"}, rsp_valid, 32'd1);
      check({tag, "_rsp"}, {rsp_id, rsp_err, rsp_data}, {26'd0, 2'(idx), exp_err, exp_data});
      @(negedge clk);
      check({tag, "_rsp_pulse"}, rsp_valid, 32'd0);
   endtask

   initial begin
      int w, lat;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      @(negedge clk);

      // Reset state and post-reset drain.
      do_reset("reset");

      // Single transaction: 3 + 2 = 5, serial bits and start strobe checked.
      set_req(0, 2'b11, 2'b10);
      serve("single", 0, 2'b11, 2'b10, 3'b101, 1'b0, 1'b1, w, lat);
      check("single_latency", lat, 32'd6);

      // All-ones then all-zeros back-to-back from requester 0.
      set_req(0, 2'b11, 2'b11);
      serve("ones", 0, 2'b11, 2'b11, 3'b110, 1'b0, 1'b1, w, lat);
      set_req(0, 2'b00, 2'b00);
      serve("zeros", 0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, w, lat);
      check("zeros_gap_wait", w, 32'd3);

      // Timeout: the adder never answers.
      m_dead = 1'b1;
      set_req(2, 2'b01, 2'b01);
      serve("tmo", 2, 2'b01, 2'b01, 3'b000, 1'b1, 1'b0, w, lat);
      check("tmo_latency", lat, 32'd19);
      check("tmo_drain_busy", busy, 32'd1);
      repeat (3) @(negedge clk);
      check("tmo_idle", busy, 32'd0);
      m_dead = 1'b0;

      // Reset while receiving the result, then a clean transaction.
      m_dly = 2;
      set_req(3, 2'b10, 2'b01);
      grab("mid", 3, w);
      repeat (6) @(negedge clk);
      do_reset("mid_reset");
      m_dly = 0;
      set_req(3, 2'b10, 2'b01);
      serve("after_reset", 3, 2'b10, 2'b01, 3'b011, 1'b0, 1'b1, w, lat);

      // Contention with the pointer at 0: grants 0,1,2,3.
      set_req(0, 2'd1, 2'd1);
      set_req(1, 2'd2, 2'd3);
      set_req(2, 2'd3, 2'd0);
      set_req(3, 2'd1, 2'd3);
      serve("cont0", 0, 2'd1, 2'd1, 3'd2, 1'b0, 1'b0, w, lat);
      serve("cont1", 1, 2'd2, 2'd3, 3'd5, 1'b0, 1'b0, w, lat);
      serve("cont2", 2, 2'd3, 2'd0, 3'd3, 1'b0, 1'b0, w, lat);
      serve("cont3", 3, 2'd1, 2'd3, 3'd4, 1'b0, 1'b0, w, lat);

      // Requesters 1 and 3 compete; requester 1 reasserts after its grant.
      set_req(1, 2'd1, 2'd0);
      set_req(3, 2'd2, 2'd2);
      serve("pair_a", 1, 2'd1, 2'd0, 3'd1, 1'b0, 1'b0, w, lat);
      set_req(1, 2'd3, 2'd1);
`ifdef SADD_FIXED_PRIO_EN
      serve("pair_b", 1, 2'd3, 2'd1, 3'd4, 1'b0, 1'b0, w, lat);
      set_req(1, 2'd0, 2'd1);
      serve("pair_c", 1, 2'd0, 2'd1, 3'd1, 1'b0, 1'b0, w, lat);
      check("pair_req3_pending", req_valid[3], 32'd1);
      req_valid[3] = 1'b0;
`else
      serve("pair_b", 3, 2'd2, 2'd2, 3'd4, 1'b0, 1'b0, w, lat);
      serve("pair_c", 1, 2'd3, 2'd1, 3'd4, 1'b0, 1'b0, w, lat);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
